uart_rx_fifo: RTL and testbench

Receive buffer placed directly downstream of the UART receiver. Captures each received byte on the receiver's one-cycle Data_Valid pulse into a small synchronous FIFO. Presents bytes to the consumer through a first-word-fall-through valid/ready read port. Tracks overflow and parity/stop framing errors as sticky status for the host register interface.

---
 rtl/uart_rx_defs.sv | 13 +
 rtl/uart_rx_err_counter.sv | 36 +++
 rtl/uart_rx_fifo.sv | 114 +++++++++++
 tb/tb_uart_rx_fifo.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_defs.sv
// Shared defaults for the UART receive path (frame width, FIFO depth, error counters).
// Latency: none, constants only.
// Backpressure: not applicable.
package uart_rx_defs;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_LOG2_DEF = 3;

  // Error event counters are 8 bits and stick at all-ones.
  localparam int                   ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_SAT = 8'd255;

endpackage

// File: rtl/uart_rx_err_counter.sv
// Rising-edge detector feeding a saturating event counter with synchronous clear.
// Latency: the count reflects an edge one cycle after the input rises.
// Backpressure: none; every edge is counted until the counter saturates.
module uart_rx_err_counter
  import uart_rx_defs::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 err,
  input  logic                 clr,
  output logic [ERR_CNT_W-1:0] cnt
);

  logic err_prev;
  logic rise;

  assign rise = err & ~err_prev;

  // Previous value of the error input, used to find 0->1 transitions.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) err_prev <= 1'b0;
    else      err_prev <= err;
  end

  // Count edges, hold at saturation; a clear coinciding with an edge leaves 1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= {{(ERR_CNT_W-1){1'b0}}, rise};
    end else if (rise && (cnt != ERR_CNT_SAT)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with FWFT read port and sticky overflow/parity/stop status; UART_RX_FIFO_ERRCNT_EN adds error edge counters.
// Latency: a byte written in cycle N is presented on rd_data with rd_valid in cycle N+1.
// Backpressure: rd_ready holds the head; writes arriving while full (without a same-cycle pop) are dropped and flagged.
module uart_rx_fifo
  import uart_rx_defs::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  input  logic                  par_err,
  input  logic                  stp_err,
  input  logic                  flush,
  input  logic                  clr_status,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  ovf_flag,
  output logic                  par_err_flag,
  output logic                  stp_err_flag,
  output logic [ERR_CNT_W-1:0]  par_err_cnt,
  output logic [ERR_CNT_W-1:0]  stp_err_cnt
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  pop;
  logic                  push;
  logic                  ovf_set;

  assign rd_valid = (fill_level != '0);
  assign full     = (fill_level == DEPTH_LVL);
  assign rd_data  = mem[rd_ptr];

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign pop     = rd_valid & rd_ready;
  assign push    = wr_valid & (~full | pop);
  // Writes lost to a flush are intentional and do not count as overflow.
  assign ovf_set = wr_valid & full & ~pop & ~flush;

  // Storage: written on an accepted push; flush leaves contents untouched.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; flush wins over any push or pop.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill_level <= fill_level + 1'b1;
        2'b01:   fill_level <= fill_level - 1'b1;
        default: fill_level <= fill_level;
      endcase
    end
  end

  // Sticky status: a set in the same cycle as clr_status survives.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovf_flag     <= 1'b0;
      par_err_flag <= 1'b0;
      stp_err_flag <= 1'b0;
    end else begin
      ovf_flag     <= ovf_set | (ovf_flag     & ~clr_status);
      par_err_flag <= par_err | (par_err_flag & ~clr_status);
      stp_err_flag <= stp_err | (stp_err_flag & ~clr_status);
    end
  end

`ifdef UART_RX_FIFO_ERRCNT_EN
  uart_rx_err_counter u_par_cnt (
    .CLK (CLK),
    .RST (RST),
    .err (par_err),
    .clr (clr_status),
    .cnt (par_err_cnt)
  );

  uart_rx_err_counter u_stp_cnt (
    .CLK (CLK),
    .RST (RST),
    .err (stp_err),
    .clr (clr_status),
    .cnt (stp_err_cnt)
  );
`else
  assign par_err_cnt = '0;
  assign stp_err_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: queue-based reference model compared every cycle, plus literal spot checks.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
// Error-counter expectations follow UART_RX_FIFO_ERRCNT_EN.
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DL    = 3;
  localparam int DEPTH = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          par_err = 1'b0;
  logic          stp_err = 1'b0;
  logic          flush = 1'b0;
  logic          clr_status = 1'b0;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic [DL:0]   fill_level;
  logic          ovf_flag;
  logic          par_err_flag;
  logic          stp_err_flag;
  logic [7:0]    par_err_cnt;
  logic [7:0]    stp_err_cnt;

  always #5 CLK = ~CLK;

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .par_err      (par_err),
    .stp_err      (stp_err),
    .flush        (flush),
    .clr_status   (clr_status),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .full         (full),
    .fill_level   (fill_level),
    .ovf_flag     (ovf_flag),
    .par_err_flag (par_err_flag),
    .stp_err_flag (stp_err_flag),
    .par_err_cnt  (par_err_cnt),
    .stp_err_cnt  (stp_err_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the FIFO is just a queue of bytes plus status bits.
  logic [7:0] m_q[$];
  bit         m_ovf, m_par, m_stp;
  bit         m_pprev, m_sprev;
  int         m_pcnt, m_scnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_ovf = 0; m_par = 0; m_stp = 0;
    m_pprev = 0; m_sprev = 0; m_pcnt = 0; m_scnt = 0;
  endtask

  function automatic int next_cnt(int cnt, bit edge_seen, bit clr);
    if (clr) return edge_seen ? 1 : 0;
    if (edge_seen) return (cnt >= 255) ? 255 : cnt + 1;
    return cnt;
  endfunction

  task automatic compare_all();
    int sz;
    sz = m_q.size();
    chk("rd_valid", rd_valid, (sz > 0));
    if (sz > 0) chk("rd_data", rd_data, m_q[0]);
    chk("full", full, (sz == DEPTH));
    chk("fill_level", fill_level, sz);
    chk("ovf_flag", ovf_flag, m_ovf);
    chk("par_err_flag", par_err_flag, m_par);
    chk("stp_err_flag", stp_err_flag, m_stp);
`ifdef UART_RX_FIFO_ERRCNT_EN
    chk("par_err_cnt", par_err_cnt, m_pcnt);
    chk("stp_err_cnt", stp_err_cnt, m_scnt);
`else
    chk("par_err_cnt", par_err_cnt, 0);
    chk("stp_err_cnt", stp_err_cnt, 0);
`endif
  endtask

  // Advance the model by the current inputs, clock the DUT once, then compare.
  task automatic tick();
    int sz;
    bit pop, push, pe, se;
    sz   = m_q.size();
    pop  = (sz > 0) && rd_ready;
    push = wr_valid && ((sz < DEPTH) || pop);
    if (wr_valid && (sz == DEPTH) && !pop && !flush) m_ovf = 1;
    else if (clr_status) m_ovf = 0;
    if (flush) m_q.delete();
    else begin
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(wr_data);
    end
    m_par = par_err || (m_par && !clr_status);
    m_stp = stp_err || (m_stp && !clr_status);
    pe = par_err && !m_pprev;
    se = stp_err && !m_sprev;
    m_pcnt = next_cnt(m_pcnt, pe, clr_status);
    m_scnt = next_cnt(m_scnt, se, clr_status);
    m_pprev = par_err;
    m_sprev = stp_err;
    @(posedge CLK);
    @(negedge CLK);
    compare_all();
  endtask

  task automatic write(input logic [7:0] d);
    wr_valid = 1; wr_data = d;
    tick();
    wr_valid = 0;
  endtask

  task automatic pop_expect(input logic [7:0] exp);
    chk("pop_data", rd_data, exp);
    rd_ready = 1;
    tick();
    rd_ready = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_fill"}, fill_level, 0);
    chk({tag, "_ovf"}, ovf_flag, 0);
    chk({tag, "_par_flag"}, par_err_flag, 0);
    chk({tag, "_stp_flag"}, stp_err_flag, 0);
    chk({tag, "_par_cnt"}, par_err_cnt, 0);
    chk({tag, "_stp_cnt"}, stp_err_cnt, 0);
  endtask

  initial begin
    m_reset();
    #12;
    check_all_zero("reset");
    @(negedge CLK);
    RST = 1;
    tick();

    // Two writes with consumer stalled, then drain.
    write(8'hA5);
    chk("lat_rd_valid", rd_valid, 1);
    chk("lat_rd_data", rd_data, 8'hA5);
    write(8'h3C);
    chk("two_fill", fill_level, 2);
    chk("two_hold", rd_data, 8'hA5);
    pop_expect(8'hA5);
    pop_expect(8'h3C);
    chk("drained_valid", rd_valid, 0);

    // Overflow: ninth byte dropped.
    for (int i = 1; i <= 9; i++) begin
      write(8'(i));
      if (i == 8) chk("full_at_8", full, 1);
    end
    chk("ovf_set", ovf_flag, 1);
    chk("ovf_fill", fill_level, 8);
    for (int i = 1; i <= 8; i++) pop_expect(8'(i));
    chk("ovf_empty", rd_valid, 0);
    clr_status = 1; tick(); clr_status = 0;
    chk("ovf_cleared", ovf_flag, 0);

    // Full plus simultaneous write and pop.
    for (int i = 0; i < 8; i++) write(8'h10 + 8'(i));
    chk("full_again", full, 1);
    chk("pre_simul_head", rd_data, 8'h10);
    wr_valid = 1; wr_data = 8'h55; rd_ready = 1;
    tick();
    wr_valid = 0; rd_ready = 0;
    chk("simul_fill", fill_level, 8);
    chk("simul_no_ovf", ovf_flag, 0);
    for (int i = 1; i < 8; i++) pop_expect(8'h10 + 8'(i));
    pop_expect(8'h55);

    // Flush with 5 entries and a concurrent write.
    for (int i = 0; i < 5; i++) write(8'h20 + 8'(i));
    chk("pre_flush_fill", fill_level, 5);
    flush = 1; wr_valid = 1; wr_data = 8'h66;
    tick();
    flush = 0; wr_valid = 0;
    chk("flush_fill", fill_level, 0);
    chk("flush_valid", rd_valid, 0);
    chk("flush_ovf", ovf_flag, 0);
    write(8'h77);
    chk("post_flush_data", rd_data, 8'h77);
    chk("post_flush_fill", fill_level, 1);
    pop_expect(8'h77);

    // Flush while full with a write does not count as overflow.
    for (int i = 0; i < 8; i++) write(8'h30 + 8'(i));
    flush = 1; wr_valid = 1; wr_data = 8'h99;
    tick();
    flush = 0; wr_valid = 0;
    chk("flush_full_ovf", ovf_flag, 0);
    chk("flush_full_fill", fill_level, 0);

    // Error flags and edge counting.
    par_err = 1; tick(); tick(); tick();
    par_err = 0; stp_err = 1; tick();
    stp_err = 0; par_err = 1; tick();
    par_err = 0; tick();
    chk("par_flag", par_err_flag, 1);
    chk("stp_flag", stp_err_flag, 1);
`ifdef UART_RX_FIFO_ERRCNT_EN
    chk("par_cnt_lit", par_err_cnt, 2);
    chk("stp_cnt_lit", stp_err_cnt, 1);
`else
    chk("par_cnt_lit", par_err_cnt, 0);
    chk("stp_cnt_lit", stp_err_cnt, 0);
`endif
    // Clear coinciding with a new parity error: flag survives, count reloads to 1.
    clr_status = 1; par_err = 1; tick();
    clr_status = 0; par_err = 0;
    chk("set_wins_par", par_err_flag, 1);
    chk("clr_stp", stp_err_flag, 0);
`ifdef UART_RX_FIFO_ERRCNT_EN
    chk("clr_edge_cnt", par_err_cnt, 1);
`endif
    clr_status = 1; tick(); clr_status = 0;
    chk("clr_all_par", par_err_flag, 0);
    chk("clr_all_cnt", par_err_cnt, 0);

    // Saturation over 300 stop-error pulses.
    for (int i = 0; i < 300; i++) begin
      stp_err = 1; tick();
      stp_err = 0; tick();
    end
`ifdef UART_RX_FIFO_ERRCNT_EN
    chk("stp_sat", stp_err_cnt, 255);
`else
    chk("stp_sat", stp_err_cnt, 0);
`endif

    // Asynchronous reset mid-burst with data and flags present.
    write(8'hC1);
    write(8'hC2);
    stp_err = 1; par_err = 1; tick();
    stp_err = 0; par_err = 0; tick();
    stp_err = 1;
    #2;
    RST = 0;
    #1;
    check_all_zero("async_rst");
    stp_err = 0;
    m_reset();
    @(posedge CLK);
    @(negedge CLK);
    check_all_zero("rst_held");
    RST = 1;
    tick();
    write(8'hE7);
    chk("post_rst_data", rd_data, 8'hE7);
    pop_expect(8'hE7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
